// File: rtl/door_input_conditioner.sv
// door_input_conditioner: synchronizes, debounces and pulse-shapes the door button and limit switches
module door_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 50,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic up_max_raw,
  input  logic dn_max_raw,
  output logic activate,
  output logic UP_max,
  output logic DN_max,
  output logic btn_db,
  output logic lockout
);
  typedef enum logic [1:0] {READY, LOCK, WAIT_REL} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  state_t state, state_nx;
  logic btn_m, btn_s, up_m, dn_m, btn_db_q, activate_nx;
  logic [CNT_W-1:0] db_cnt, lk_cnt, lk_cnt_nx;
  // two-flop synchronizers for the three asynchronous inputs
  always_ff @(posedge clk or posedge rst)
    if (rst) {btn_m, btn_s, up_m, UP_max, dn_m, DN_max} <= '0;
    else begin
      btn_m  <= btn_raw;
      btn_s  <= btn_m;
      up_m   <= up_max_raw;
      UP_max <= up_m;
      dn_m   <= dn_max_raw;
      DN_max <= dn_m;
    end
  // debouncer: flip only after the synchronized level disagrees for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + CNT_W'(1);
    end
  // pulse FSM state, lockout counter and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= READY;
      lk_cnt   <= '0;
      activate <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      state    <= state_nx;
      lk_cnt   <= lk_cnt_nx;
      activate <= activate_nx;
      lockout  <= state_nx != READY;
    end
  // next-state: one pulse per debounced rising edge, then ignore presses for the lockout window
  always_comb begin
    state_nx    = state;
    lk_cnt_nx   = lk_cnt;
    activate_nx = 1'b0;
    case (state)
      READY:
        if (btn_db && !btn_db_q) begin
          activate_nx = 1'b1;
          lk_cnt_nx   = '0;
          state_nx    = LOCK;
        end
      LOCK:
        if (lk_cnt == LK_LAST) begin
          lk_cnt_nx = '0;
          state_nx  = btn_db ? WAIT_REL : READY;
        end else lk_cnt_nx = lk_cnt + CNT_W'(1);
      WAIT_REL: state_nx = btn_db ? WAIT_REL : READY;
      default:  state_nx = READY;
    endcase
  end
endmodule

// File: tb/tb_door_input_conditioner.sv
// tb_door_input_conditioner: scoreboard bench for the door input conditioner
module tb_door_input_conditioner;
  localparam int D = 4;
  localparam int L = 16;
  logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, up_max_raw = 1'b0, dn_max_raw = 1'b0;
  logic activate, UP_max, DN_max, btn_db, lockout;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int exp_q[$];
  int uq[$], dq[$];

  door_input_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .up_max_raw(up_max_raw), .dn_max_raw(dn_max_raw),
    .activate(activate), .UP_max(UP_max), .DN_max(DN_max), .btn_db(btn_db), .lockout(lockout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // every activate pulse must match the next expected cycle in the scoreboard
  always @(negedge clk)
    if (activate) begin
      if (exp_q.size() == 0) chk("spurious_activate", activate, 0);
      else chk("activate_cycle", cyc, exp_q.pop_front());
    end

  initial begin
    int c, r;
    tick(3);
    chk("rst_activate", activate, 0);
    chk("rst_up", UP_max, 0);
    chk("rst_dn", DN_max, 0);
    chk("rst_btn_db", btn_db, 0);
    chk("rst_lockout", lockout, 0);
    rst = 1'b0;
    tick(2);
    // asynchronous reset in the middle of a lockout with every input high
    c = cyc;
    {btn_raw, up_max_raw, dn_max_raw} = 3'b111;
    exp_q.push_back(c + 7);
    tick(10);
    chk("pre_rst_lockout", lockout, 1);
    chk("pre_rst_up", UP_max, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_activate", activate, 0);
    chk("async_up", UP_max, 0);
    chk("async_dn", DN_max, 0);
    chk("async_btn_db", btn_db, 0);
    chk("async_lockout", lockout, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(cyc + 7);
    tick(12);
    chk("held_rst_lockout", lockout, 1);
    {btn_raw, up_max_raw, dn_max_raw} = 3'b000;
    tick(25);
    chk("s1_pending", exp_q.size(), 0);
    chk("s1_lockout", lockout, 0);
    // clean press held into WAIT_REL, then release
    c = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(c + 7);
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      chk("s2_btn_db", btn_db, int'(cyc - c >= 6));
      chk("s2_lockout", lockout, int'(cyc - c >= 7));
    end
    r = cyc;
    btn_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("s2_rel_btn_db", btn_db, int'(cyc - r < 6));
      chk("s2_rel_lockout", lockout, int'(cyc - r < 7));
    end
    chk("s2_pending", exp_q.size(), 0);
    // bounce 1,0,1,0 then settle high
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      btn_raw = ~i[0];
      tick(1);
    end
    btn_raw = 1'b1;
    exp_q.push_back(c + 11);
    for (int i = 5; i <= 30; i++) begin
      tick(1);
      chk("s3_btn_db", btn_db, int'(cyc - c >= 10));
    end
    btn_raw = 1'b0;
    tick(12);
    chk("s3_pending", exp_q.size(), 0);
    chk("s3_lockout", lockout, 0);
    // three-cycle glitch must be filtered out
    c = cyc;
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("s4_btn_db", btn_db, 0);
      chk("s4_lockout", lockout, 0);
    end
    // press, release and re-press debounced inside the lockout window: discarded
    c = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(c + 7);
    for (int i = 1; i <= 30; i++) begin
      if (cyc - c == 5) btn_raw = 1'b0;
      if (cyc - c == 13) btn_raw = 1'b1;
      tick(1);
      chk("s5_btn_db", btn_db, int'((cyc - c >= 6 && cyc - c < 11) || cyc - c >= 19));
      chk("s5_lockout", lockout, int'(cyc - c >= 7));
    end
    btn_raw = 1'b0;
    tick(10);
    chk("s5_lockout_fall", lockout, 0);
    c = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(c + 7);
    tick(10);
    btn_raw = 1'b0;
    tick(30);
    chk("s5_pending", exp_q.size(), 0);
    // limit switches follow with two-cycle latency and no filtering
    for (int i = 0; i < 16; i++) begin
      if (uq.size() == 2) begin
        chk("up_max", UP_max, uq.pop_front());
        chk("dn_max", DN_max, dq.pop_front());
      end
      up_max_raw = i[0];
      dn_max_raw = 1'($urandom_range(0, 1));
      uq.push_back(int'(up_max_raw));
      dq.push_back(int'(dn_max_raw));
      tick(1);
    end
    // reset during LOCK with lk_cnt at 3
    c = cyc;
    btn_raw = 1'b1;
    exp_q.push_back(c + 7);
    tick(10);
    chk("s6_pre_lockout", lockout, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_lockout", lockout, 0);
    chk("s6_rst_btn_db", btn_db, 0);
    btn_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("s6_ready_lockout", lockout, 0);
    end
    chk("final_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
